// File: rtl/data_mem_if.sv
// Load/store request and response bundle between the MEM stage and the data memory.
// master = MEM stage (requester), slave = data memory responder.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory for the MEM stage: one request at a time, RV32I load
// extension, byte/half/word stores, and misaligned/out-of-range/illegal-funct3 flagging.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        accept;
  logic        enter_resp;

  logic [31:0] mem [DEPTH_WORDS];

  // With LATENCY==1 the access happens on the accept edge itself, so the
  // request fields come straight from the bus while IDLE and from the latches later.
  logic        cur_we;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        err;
  logic [AW-1:0] widx;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [3:0]  be;
  logic [31:0] wword;

  always_comb begin
    cur_we    = (state == IDLE) ? bus.req_we     : we_q;
    cur_f3    = (state == IDLE) ? bus.req_funct3 : f3_q;
    cur_addr  = (state == IDLE) ? bus.req_addr   : addr_q;
    cur_wdata = (state == IDLE) ? bus.req_wdata  : wdata_q;
  end

  always_comb begin
    err = 1'b0;
    if (cur_f3[1:0] == 2'b01 && cur_addr[0]) err = 1'b1;
    if (cur_f3[1:0] == 2'b10 && cur_addr[1:0] != 2'b00) err = 1'b1;
    if ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS)) err = 1'b1;
    if (cur_we ? (cur_f3 > 3'b010) : (cur_f3 == 3'b011 || cur_f3[2:1] == 2'b11)) err = 1'b1;
  end

  always_comb begin
    widx    = cur_addr[AW+1:2];
    rd_word = mem[widx];
    case (cur_addr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (cur_f3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_val = {24'd0, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_val = {16'd0, rd_half};
      3'b010:  load_val = rd_word;
      default: load_val = '0;
    endcase
    case (cur_f3[1:0])
      2'b00: begin
        be    = 4'b0001 << cur_addr[1:0];
        wword = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{cur_wdata[15:0]}};
      end
      default: begin
        be    = '1;
        wword = cur_wdata;
      end
    endcase
  end

  assign accept     = bus.req_valid && bus.req_ready;
  assign enter_resp = (state != RESP) && (state_n == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE) && !rst;
    bus.rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      we_q          <= 1'b0;
      f3_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        bus.rsp_err   <= err;
        bus.rsp_rdata <= (cur_we || err) ? '0 : load_val;
      end
    end
  end

  // No reset on the array: contents survive rst and are preloaded externally.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_we && !err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance at LATENCY=2, one at LATENCY=1.
`timescale 1ns/1ps
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  data_mem_if bus2 ();
  data_mem_if bus1 ();

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request on the LATENCY=2 instance; starts and ends on a falling edge.
  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int lat);
    chk({tag, "_ready"}, 32'(bus2.req_ready), 32'd1);
    bus2.req_valid  = 1'b1;
    bus2.req_we     = we;
    bus2.req_funct3 = f3;
    bus2.req_addr   = addr;
    bus2.req_wdata  = wdata;
    @(posedge clk);
    #1 bus2.req_valid = 1'b0;
    lat = 0;
    rdata = '0;
    err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus2.rsp_valid) begin
        lat = k;
        rdata = bus2.rsp_rdata;
        err = bus2.rsp_err;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus2.rsp_valid), 32'd0);
  endtask

  task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          lat;
    txn(tag, 1'b0, f3, addr, 32'd0, rd, e, lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(e), 32'(exp_err));
  endtask

  task automatic st(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          lat;
    txn(tag, 1'b1, f3, addr, wdata, rd, e, lat);
    chk({tag, "_rdata"}, rd, 32'd0);
    chk({tag, "_err"}, 32'(e), 32'(exp_err));
  endtask

  initial begin
    int          seen;
    logic [2:0]  f3s  [3];
    logic        wes  [3];
    logic [31:0] adrs [3];
    logic [31:0] exps [3];

    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_funct3 = '0;
    bus2.req_addr = '0;    bus2.req_wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_funct3 = '0;
    bus1.req_addr = '0;    bus1.req_wdata = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus2.req_ready), 32'd0);
    chk("rst_valid", 32'(bus2.rsp_valid), 32'd0);
    chk("rst_rdata", bus2.rsp_rdata, 32'd0);
    chk("rst_err",   32'(bus2.rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Preload through the store path
    st("pre_w1", 3'b010, 32'd4,  32'h8000_00F0, 1'b0);
    st("pre_w2", 3'b010, 32'd8,  32'h1234_80FF, 1'b0);
    st("pre_w3", 3'b010, 32'd12, 32'h0000_0000, 1'b0);
    st("pre_w0", 3'b010, 32'd0,  32'h1111_2222, 1'b0);

    ld("lw4",   3'b010, 32'd4,  32'h8000_00F0, 1'b0);
    ld("lb8",   3'b000, 32'd8,  32'hFFFF_FFFF, 1'b0);
    ld("lbu8",  3'b100, 32'd8,  32'h0000_00FF, 1'b0);
    ld("lh10",  3'b001, 32'd10, 32'h0000_1234, 1'b0);
    ld("lhu8",  3'b101, 32'd8,  32'h0000_80FF, 1'b0);
    ld("lbu11", 3'b100, 32'd11, 32'h0000_0012, 1'b0);

    st("sb13",  3'b000, 32'd13, 32'h0000_00AB, 1'b0);
    ld("lw12a", 3'b010, 32'd12, 32'h0000_AB00, 1'b0);
    st("sh14",  3'b001, 32'd14, 32'h7777_5566, 1'b0);
    ld("lw12b", 3'b010, 32'd12, 32'h5566_AB00, 1'b0);

    ld("lw6_mis",   3'b010, 32'd6,    32'd0, 1'b1);
    st("sh3_mis",   3'b001, 32'd3,    32'h0000_FFFF, 1'b1);
    ld("lw0_keep",  3'b010, 32'd0,    32'h1111_2222, 1'b0);
    ld("lw_oor",    3'b010, 32'd4096, 32'd0, 1'b1);
    ld("lb_oor",    3'b000, 32'd4099, 32'd0, 1'b1);
    ld("ld_f3_011", 3'b011, 32'd0,    32'd0, 1'b1);
    ld("ld_f3_110", 3'b110, 32'd0,    32'd0, 1'b1);
    st("st_f3_100", 3'b100, 32'd0,    32'hFFFF_FFFF, 1'b1);
    ld("lw0_keep2", 3'b010, 32'd0,    32'h1111_2222, 1'b0);
    st("sw_last",   3'b010, 32'd4092, 32'hA5A5_5A5A, 1'b0);
    ld("lw_last",   3'b010, 32'd4092, 32'hA5A5_5A5A, 1'b0);

    // Reset while the store is waiting: no commit, no response
    bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_funct3 = 3'b010;
    bus2.req_addr = 32'd0; bus2.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 bus2.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("midrst_ready_low", 32'(bus2.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_ready_high", 32'(bus2.req_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus2.rsp_valid) seen++;
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    ld("midrst_mem0", 3'b010, 32'd0, 32'h1111_2222, 1'b0);

    // LATENCY=1, req_valid held high across back-to-back requests
    wes[0] = 1'b1; f3s[0] = 3'b010; adrs[0] = 32'd0; exps[0] = 32'h0000_0000;
    wes[1] = 1'b0; f3s[1] = 3'b100; adrs[1] = 32'd3; exps[1] = 32'h0000_00CA;
    wes[2] = 1'b0; f3s[2] = 3'b001; adrs[2] = 32'd2; exps[2] = 32'hFFFF_CAFE;
    bus1.req_wdata = 32'hCAFE_0001;
    bus1.req_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b%0d_ready_hi", i), 32'(bus1.req_ready), 32'd1);
      chk($sformatf("b2b%0d_idle_valid", i), 32'(bus1.rsp_valid), 32'd0);
      bus1.req_we = wes[i]; bus1.req_funct3 = f3s[i]; bus1.req_addr = adrs[i];
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b%0d_ready_lo", i), 32'(bus1.req_ready), 32'd0);
      if (bus1.rsp_valid) seen++;
      chk($sformatf("b2b%0d_rdata", i), bus1.rsp_rdata, exps[i]);
      chk($sformatf("b2b%0d_err", i), 32'(bus1.rsp_err), 32'd0);
      @(negedge clk);
    end
    bus1.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus1.rsp_valid) seen++;
    end
    chk("b2b_rsp_count", 32'(seen), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
